// File: rtl/mlp_pkg.sv
// Shared MLP constants and the argmax controller state type.
// Imported by argmax_cmp and argmax_tracker.
package mlp_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Signed candidate-vs-current compare with the tie rule.
// ARGMAX_TIE_LAST_EN: ties go to the later index (>=), else strict >.
module argmax_cmp
    import mlp_pkg::*;
(
    input  logic signed [DATA_W-1:0] cand,
    input  logic signed [DATA_W-1:0] cur,
    output logic                     take
);

    // Decide whether the candidate replaces the running maximum
    always_comb begin
`ifdef ARGMAX_TIE_LAST_EN
        take = (cand >= cur);
`else
        take = (cand > cur);
`endif
    end

endmodule

// File: rtl/argmax_tracker.sv
// Streams N_OUT output-layer values and reports the max value and index.
// Tie behaviour is set in argmax_cmp by ARGMAX_TIE_LAST_EN.
module argmax_tracker
    import mlp_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int IDX_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]         max_idx,
    output logic                     done,
    output logic                     busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

    argmax_state_e             state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  max_val_q, max_val_d;
    logic [IDX_W-1:0]          max_idx_q, max_idx_d;
    logic                      done_q, done_d;
    logic                      take;
    logic                      xfer;

    argmax_cmp u_cmp (
        .cand (in_data),
        .cur  (max_val_q),
        .take (take)
    );

    assign xfer = in_valid && (state_q == ST_COLLECT);

    // Next-state: start wins over any same-cycle transfer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        done_d    = done_q;
        if (start) begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (xfer) begin
            if ((cnt_q == '0) || take) begin
                max_val_d = in_data;
                max_idx_d = cnt_q;
            end
            if (cnt_q == LAST) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == ST_COLLECT);
    assign busy     = (state_q == ST_COLLECT);
    assign max_val  = max_val_q;
    assign max_idx  = max_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_argmax_tracker.sv
// Self-checking bench for argmax_tracker: directed frames plus random
// frames against a two-pass max/index reference model.
module tb_argmax_tracker;

    localparam int N = 10;

    logic               clk;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic signed [15:0] max_val;
    logic [3:0]         max_idx;
    logic               done;
    logic               busy;

    int compared;
    int mismatched;

    typedef logic signed [15:0] frame_t [N];

    argmax_tracker #(.N_OUT(N), .IDX_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .max_val  (max_val),
        .max_idx  (max_idx),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: find the maximum value, then pick the first (or last,
    // with the tie-last option) position holding that value.
    function automatic void ref_max(input frame_t v,
                                    output logic signed [15:0] mv,
                                    output logic [15:0] mi);
        int best;
        best = -32768;
        for (int i = 0; i < N; i++)
            if (int'(v[i]) > best) best = int'(v[i]);
        mv = 16'(best);
        mi = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            if (int'(v[i]) == best) begin
`ifdef ARGMAX_TIE_LAST_EN
                mi = 16'(i);
`else
                if (mi == 16'hFFFF) mi = 16'(i);
`endif
            end
        end
    endfunction

    // Send a frame; inputs change on the falling edge, checks on the next
    task automatic run_frame(input frame_t v, input bit do_start,
                             input bit gaps, input string tag);
        logic signed [15:0] mv;
        logic [15:0]        mi;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_done_cleared"}, {15'b0, done}, 16'd0);
            chk({tag, "_busy"}, {15'b0, busy}, 16'd1);
        end
        for (int i = 0; i < N; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                @(negedge clk);
                chk({tag, "_done_gap"}, {15'b0, done}, 16'd0);
            end
            chk({tag, "_ready"}, {15'b0, in_ready}, 16'd1);
            in_valid = 1'b1;
            in_data  = v[i];
            @(negedge clk);
            if (i < N - 1)
                chk({tag, "_done_early"}, {15'b0, done}, 16'd0);
        end
        in_valid = 1'b0;
        ref_max(v, mv, mi);
        chk({tag, "_done"}, {15'b0, done}, 16'd1);
        chk({tag, "_busy_off"}, {15'b0, busy}, 16'd0);
        chk({tag, "_max_val"}, mv, max_val);
        chk({tag, "_max_idx"}, mi, {12'b0, max_idx});
        // DONE must ignore further data and hold the result
        in_valid = 1'b1;
        in_data  = 16'sh7FFF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_hold_val"}, mv, max_val);
        chk({tag, "_hold_idx"}, mi, {12'b0, max_idx});
        chk({tag, "_hold_done"}, {15'b0, done}, 16'd1);
    endtask

    initial begin
        frame_t f;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;

        // Reset held, then released with data but no start
        repeat (3) @(negedge clk);
        chk("rst_ready", {15'b0, in_ready}, 16'd0);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'sd55;
        repeat (3) @(negedge clk);
        chk("nostart_ready", {15'b0, in_ready}, 16'd0);
        chk("nostart_done", {15'b0, done}, 16'd0);
        chk("nostart_val", max_val, 16'd0);
        chk("nostart_idx", {12'b0, max_idx}, 16'd0);
        in_valid = 1'b0;

        // Back-to-back mixed-sign frame
        f = '{16'sd3, -16'sd5, 16'sd12, 16'sd7, 16'sd0,
              16'sd1, 16'sd2, 16'sd9, 16'sd11, 16'sd4};
        run_frame(f, 1'b1, 1'b0, "mixed");
        chk("mixed_const_val", max_val, 16'd12);
        chk("mixed_const_idx", {12'b0, max_idx}, 16'd2);

        // All-negative frame with gaps
        for (int i = 0; i < N; i++) f[i] = 16'(-(i + 1));
        run_frame(f, 1'b1, 1'b1, "neg");
        chk("neg_const_val", max_val, 16'hFFFF);
        chk("neg_const_idx", {12'b0, max_idx}, 16'd0);

        // Tie at indices 1 and 6
        f = '{16'sd0, 16'sd8, 16'sd3, -16'sd4, 16'sd7,
              16'sd5, 16'sd8, 16'sd1, 16'sd2, 16'sd6};
        run_frame(f, 1'b1, 1'b0, "tie");
`ifdef ARGMAX_TIE_LAST_EN
        chk("tie_const_idx", {12'b0, max_idx}, 16'd6);
`else
        chk("tie_const_idx", {12'b0, max_idx}, 16'd1);
`endif

        // Async reset after 5 transfers
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'sd1000 + 16'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_val", max_val, 16'd0);
        chk("arst_idx", {12'b0, max_idx}, 16'd0);
        chk("arst_busy", {15'b0, busy}, 16'd0);
        chk("arst_ready", {15'b0, in_ready}, 16'd0);
        chk("arst_done", {15'b0, done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) f[i] = 16'sd10 * 16'(i % 4) - 16'sd20;
        run_frame(f, 1'b1, 1'b0, "post_rst");

        // Abort after 4 transfers; restart carries a transfer that is dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'sd100;
            @(negedge clk);
        end
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd32000;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("abort_done", {15'b0, done}, 16'd0);
        chk("abort_busy", {15'b0, busy}, 16'd1);
        for (int i = 0; i < N; i++) f[i] = 16'(i);
        f[9] = 16'sd20;
        run_frame(f, 1'b0, 1'b0, "abort");
        chk("abort_const_val", max_val, 16'd20);
        chk("abort_const_idx", {12'b0, max_idx}, 16'd9);

        // Random frames, some with a narrow range to provoke ties
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) f[i] = 16'($urandom);
                else f[i] = 16'($urandom_range(0, 6)) - 16'sd3;
            end
            run_frame(f, 1'b1, (k % 3) == 0, $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
